// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared types, widths and helpers for the register scoreboard
package sb_pkg;

  localparam int REG_IDX_W     = 5;
  localparam int CNT_W_DEFAULT = 2;
  localparam int PENDING_W     = 6;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // x0 is hardwired zero, so it is never tracked as a producer or consumer
  function automatic logic is_zero_reg(input reg_idx_t idx);
    return idx == '0;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - single-register saturating up/down outstanding-write counter
module sb_counter
  import sb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins; simultaneous inc and dec cancel; never wrap in either direction
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !dec && cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - decode-stage RAW scoreboard; optional SB_WB_BYPASS_EN write-first bypass
module reg_scoreboard
  import sb_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  input  logic                 iss_we,
  input  logic [4:0]           iss_rd,
  input  logic [4:0]           iss_rs1,
  input  logic [4:0]           iss_rs2,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_rd,
  input  logic                 flush,
  output logic                 stall,
  output logic                 iss_fire,
  output logic [PENDING_W-1:0] pending_cnt,
  output logic                 sb_err
);

  localparam int NUM_SLOTS = 1 << REG_IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PENDING_W-1:0] PEND_MAX = '1;

  // Indexed by the full 5-bit register index; untracked slots read as zero
  logic [CNT_W-1:0] cnt_arr [NUM_SLOTS];

  logic rs1_busy;
  logic rs2_busy;
  logic rd_sat;
  logic inc_any;
  logic dec_any;
  logic wb_orphan;

  assign cnt_arr[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic hit_iss;
    logic hit_wb;

    assign hit_iss = inc_any && (iss_rd == REG_IDX_W'(r));
    assign hit_wb  = dec_any && (wb_rd == REG_IDX_W'(r));

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (hit_iss),
      .dec (hit_wb),
      .cnt (cnt_arr[r])
    );
  end

  for (genvar r = NUM_REGS; r < NUM_SLOTS; r++) begin : g_unused
    assign cnt_arr[r] = '0;
  end

  // Zero-latency hazard check against the current pending state
  always_comb begin
    rs1_busy  = !is_zero_reg(iss_rs1) && (cnt_arr[iss_rs1] != '0);
    rs2_busy  = !is_zero_reg(iss_rs2) && (cnt_arr[iss_rs2] != '0);
`ifdef SB_WB_BYPASS_EN
    // The last outstanding write retiring this cycle is visible to readers now
    if (wb_valid && wb_rd == iss_rs1 && cnt_arr[iss_rs1] == CNT_ONE) rs1_busy = 1'b0;
    if (wb_valid && wb_rd == iss_rs2 && cnt_arr[iss_rs2] == CNT_ONE) rs2_busy = 1'b0;
`endif
    rd_sat    = iss_we && !is_zero_reg(iss_rd) && (cnt_arr[iss_rd] == CNT_MAX);
    stall     = iss_valid && (rs1_busy || rs2_busy || rd_sat);
    iss_fire  = iss_valid && !stall && !flush;
    inc_any   = iss_fire && iss_we && !is_zero_reg(iss_rd) && (32'(iss_rd) < NUM_REGS);
    dec_any   = wb_valid && !is_zero_reg(wb_rd) && (cnt_arr[wb_rd] != '0);
    wb_orphan = wb_valid && !is_zero_reg(wb_rd) && (cnt_arr[wb_rd] == '0);
  end

  // Running total of in-flight writes; at most one issue and one retire per cycle
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pending_cnt <= '0;
    end else if (inc_any && !dec_any && pending_cnt != PEND_MAX) begin
      pending_cnt <= pending_cnt + PENDING_W'(1);
    end else if (dec_any && !inc_any && pending_cnt != '0) begin
      pending_cnt <= pending_cnt - PENDING_W'(1);
    end
  end

  // A retire with nothing outstanding means issue/writeback have lost sync
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else if (wb_orphan && !flush) begin
      sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - self-checking bench for reg_scoreboard with a behavioural model
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       iss_valid;
  logic       iss_we;
  logic [4:0] iss_rd;
  logic [4:0] iss_rs1;
  logic [4:0] iss_rs2;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       flush;
  logic       stall;
  logic       iss_fire;
  logic [5:0] pending_cnt;
  logic       sb_err;

  int checks = 0;
  int errors = 0;

  localparam int MAXC = 3;
  localparam int PMAX = 63;
`ifdef SB_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Reference state: outstanding writes per register, total, sticky error
  int mcnt [32];
  int mpend;
  bit merr;

  reg_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .iss_valid   (iss_valid),
    .iss_we      (iss_we),
    .iss_rd      (iss_rd),
    .iss_rs1     (iss_rs1),
    .iss_rs2     (iss_rs2),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .flush       (flush),
    .stall       (stall),
    .iss_fire    (iss_fire),
    .pending_cnt (pending_cnt),
    .sb_err      (sb_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_busy(input int rs);
    if (rs == 0 || mcnt[rs] == 0) return 1'b0;
    if (BYPASS && wb_valid && int'(wb_rd) == rs && mcnt[rs] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    return iss_valid && (m_busy(int'(iss_rs1)) || m_busy(int'(iss_rs2)) ||
                         (iss_we && iss_rd != 0 && mcnt[iss_rd] == MAXC));
  endfunction

  function automatic bit m_fire();
    return iss_valid && !m_stall() && !flush;
  endfunction

  task automatic step();
    bit fire;
    bit inc;
    bit dec;
    fire = m_fire();
    @(posedge clk);
    if (rst || flush) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      mpend = 0;
      if (rst) merr = 1'b0;
    end else begin
      inc = fire && iss_we && iss_rd != 0;
      dec = wb_valid && wb_rd != 0 && mcnt[wb_rd] > 0;
      if (wb_valid && wb_rd != 0 && mcnt[wb_rd] == 0) merr = 1'b1;
      if (inc) mcnt[iss_rd] = mcnt[iss_rd] + 1;
      if (dec) mcnt[wb_rd] = mcnt[wb_rd] - 1;
      mpend = mpend + int'(inc) - int'(dec);
      if (mpend > PMAX) mpend = PMAX;
      if (mpend < 0) mpend = 0;
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; iss_valid = 0; iss_we = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic issue(input int rd);
    idle();
    iss_valid = 1; iss_we = 1; iss_rd = 5'(rd);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", pending_cnt); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err got %b want 0", sb_err); end
    issue(5); iss_rs1 = 5; iss_rs2 = 9; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (iss_fire !== 1'b1) begin errors++; $display("FAIL reset_fire got %b want 1", iss_fire); end
    idle();
  endtask

  task automatic test_raw();
    do_reset();
    issue(5); #1;
    checks++; if (iss_fire !== 1'b1) begin errors++; $display("FAIL raw_issue_fire got %b want 1", iss_fire); end
    step();
    idle(); iss_valid = 1; iss_rs1 = 5; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_dep_stall got %b want 1", stall); end
    checks++; if (iss_fire !== 1'b0) begin errors++; $display("FAIL raw_dep_fire got %b want 0", iss_fire); end
    step();
    wb_valid = 1; wb_rd = 5; #1;
    checks++; if (stall !== !BYPASS) begin errors++; $display("FAIL raw_wb_stall got %b want %b", stall, !BYPASS); end
    step();
    wb_valid = 0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_after_wb_stall got %b want 0", stall); end
    checks++; if (iss_fire !== 1'b1) begin errors++; $display("FAIL raw_after_wb_fire got %b want 1", iss_fire); end
    step();
    checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL raw_pending got %0d want 0", pending_cnt); end
    idle();
  endtask

  task automatic test_zero_reg();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      issue(0); wb_valid = i[0]; wb_rd = 0; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall[%0d] got %b want 0", i, stall); end
      step();
      checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL zero_pending[%0d] got %0d want 0", i, pending_cnt); end
    end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL zero_sb_err got %b want 0", sb_err); end
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(7); #1;
      checks++; if (iss_fire !== 1'b1) begin errors++; $display("FAIL sat_fire[%0d] got %b want 1", i, iss_fire); end
      step();
    end
    checks++; if (pending_cnt !== 6'd3) begin errors++; $display("FAIL sat_pending got %0d want 3", pending_cnt); end
    issue(7); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_rd_stall got %b want 1", stall); end
    step();
    checks++; if (pending_cnt !== 6'd3) begin errors++; $display("FAIL sat_hold_pending got %0d want 3", pending_cnt); end
    wb_valid = 1; wb_rd = 7; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_wb_stall got %b want 1", stall); end
    step();
    wb_valid = 0; #1;
    checks++; if (pending_cnt !== 6'd2) begin errors++; $display("FAIL sat_wb_pending got %0d want 2", pending_cnt); end
    checks++; if (iss_fire !== 1'b1) begin errors++; $display("FAIL sat_refire got %b want 1", iss_fire); end
    step();
    checks++; if (pending_cnt !== 6'd3) begin errors++; $display("FAIL sat_refill_pending got %0d want 3", pending_cnt); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_refill_stall got %b want 1", stall); end
    idle();
  endtask

  task automatic test_same_cycle();
    do_reset();
    issue(9); step();
    issue(9); wb_valid = 1; wb_rd = 9; #1;
    checks++; if (iss_fire !== 1'b1) begin errors++; $display("FAIL same_fire got %b want 1", iss_fire); end
    step();
    checks++; if (pending_cnt !== 6'd1) begin errors++; $display("FAIL same_pending got %0d want 1", pending_cnt); end
    idle(); iss_valid = 1; iss_rs2 = 9; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL same_still_busy got %b want 1", stall); end
    wb_valid = 1; wb_rd = 9; step();
    wb_valid = 0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL same_freed got %b want 0", stall); end
    checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL same_final_pending got %0d want 0", pending_cnt); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    issue(3); step();
    issue(4); step();
    issue(10); step();
    checks++; if (pending_cnt !== 6'd3) begin errors++; $display("FAIL flush_pre_pending got %0d want 3", pending_cnt); end
    issue(11); flush = 1; #1;
    checks++; if (iss_fire !== 1'b0) begin errors++; $display("FAIL flush_fire got %b want 0", iss_fire); end
    step();
    idle();
    checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL flush_pending got %0d want 0", pending_cnt); end
    iss_valid = 1; iss_rs1 = 3; iss_rs2 = 11; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_rs_3_11 got %b want 0", stall); end
    iss_rs1 = 10; iss_rs2 = 4; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_rs_10_4 got %b want 0", stall); end
    idle();
  endtask

  task automatic test_sb_err();
    do_reset();
    wb_valid = 1; wb_rd = 12; step();
    idle();
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", sb_err); end
    checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL err_pending got %0d want 0", pending_cnt); end
    issue(2); step();
    idle(); wb_valid = 1; wb_rd = 2; step();
    idle();
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_held got %b want 1", sb_err); end
    rst = 1; step(); rst = 0;
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", sb_err); end
  endtask

  task automatic test_pending_clamp();
    do_reset();
    for (int r = 1; r < 32; r++) begin
      for (int k = 0; k < 3; k++) begin
        issue(r); step();
      end
    end
    idle();
    checks++; if (pending_cnt !== 6'd63) begin errors++; $display("FAIL clamp_top got %0d want 63", pending_cnt); end
    wb_valid = 1; wb_rd = 1; step();
    idle();
    checks++; if (pending_cnt !== 6'd62) begin errors++; $display("FAIL clamp_dec got %0d want 62", pending_cnt); end
    issue(31); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL clamp_sat_stall got %b want 1", stall); end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst       = ($urandom % 90) == 0;
      flush     = ($urandom % 40) == 0;
      iss_valid = ($urandom % 4) != 0;
      iss_we    = ($urandom % 4) != 0;
      iss_rd    = 5'($urandom % 8);
      iss_rs1   = 5'($urandom % 8);
      iss_rs2   = 5'($urandom % 8);
      wb_valid  = ($urandom % 2) != 0;
      wb_rd     = 5'($urandom % 8);
      #1;
      checks++; if (stall !== m_stall()) begin errors++; $display("FAIL rand_stall[%0d] got %b want %b", n, stall, m_stall()); end
      checks++; if (iss_fire !== m_fire()) begin errors++; $display("FAIL rand_fire[%0d] got %b want %b", n, iss_fire, m_fire()); end
      step();
      checks++; if (int'(pending_cnt) != mpend) begin errors++; $display("FAIL rand_pending[%0d] got %0d want %0d", n, pending_cnt, mpend); end
      checks++; if (sb_err !== merr) begin errors++; $display("FAIL rand_sb_err[%0d] got %b want %b", n, sb_err, merr); end
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    foreach (mcnt[i]) mcnt[i] = 0;
    mpend = 0;
    merr = 1'b0;
    test_reset();
    test_raw();
    test_zero_reg();
    test_saturation();
    test_same_cycle();
    test_flush();
    test_sb_err();
    test_pending_clamp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
